// File: rtl/fios_operand_server.sv
// Operand/result server for the FIOS Montgomery multiplier: buffers A, B and P
// from the host, feeds them to the multiplier on demand, then streams results out.
module fios_operand_server #(
  parameter int s     = 8,
  parameter int PE_NB = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  load_valid_i,
  input  logic [1:0]            load_sel_i,
  input  logic [16:0]           load_word_i,
  output logic                  load_ready_o,
  input  logic                  go_i,
  output logic                  busy_o,
  output logic                  start_o,
  output logic [PE_NB*17-1:0]   a_o,
  input  logic                  a_shift_i,
  output logic [16:0]           b_o,
  output logic [16:0]           p_o,
  input  logic                  b_fetch_i,
  input  logic                  p_fetch_i,
  input  logic                  RES_push_i,
  input  logic [16:0]           RES_i,
  input  logic                  done_i,
  output logic                  res_valid_o,
  output logic [16:0]           res_word_o,
  input  logic                  res_ready_i,
  output logic                  err_o
);

  localparam int AW   = (s > 1) ? $clog2(s) : 1;
  localparam int WW   = $clog2(s + 1);
  localparam int NWIN = (s + PE_NB - 1) / PE_NB;
  localparam int GW   = $clog2(NWIN + 1);
  localparam logic [AW-1:0] LAST    = AW'(s - 1);
  localparam logic [WW-1:0] WP_FULL = WW'(s);
  localparam logic [GW-1:0] G_SAT   = GW'(NWIN);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nxt;

  logic [16:0] a_mem [s];
  logic [16:0] b_mem [s];
  logic [16:0] p_mem [s];
  logic [16:0] r_mem [s];

  logic [AW-1:0] la, lb, lp;
  logic [AW-1:0] bp, pp, rp, bp_nxt, pp_nxt, rp_nxt;
  logic [WW-1:0] wp, wp_nxt;
  logic [GW-1:0] g, g_nxt;
  logic [PE_NB*17-1:0] a_nxt;
  logic go_acc, ld_acc, run, push_ok, drain_acc, err_nxt;
  int   idx;

  always_comb begin
    go_acc    = (state == IDLE) && go_i;
    ld_acc    = (state == IDLE) && load_valid_i && (load_sel_i != 2'd3);
    run       = (state == RUN);
    push_ok   = run && RES_push_i && (wp != WP_FULL);
    drain_acc = (state == DRAIN) && res_valid_o && res_ready_i;

    state_nxt = state;
    g_nxt     = g;
    bp_nxt    = bp;
    pp_nxt    = pp;
    wp_nxt    = wp;
    rp_nxt    = rp;
    err_nxt   = err_o;

    if (go_acc) begin
      state_nxt = RUN;
      g_nxt     = '0;
      bp_nxt    = '0;
      pp_nxt    = '0;
      wp_nxt    = '0;
      rp_nxt    = '0;
      err_nxt   = 1'b0;
    end
    if (run) begin
      if (a_shift_i && (g != G_SAT)) g_nxt = g + 1'b1;
      if (b_fetch_i) bp_nxt = (bp == LAST) ? '0 : bp + 1'b1;
      if (p_fetch_i) pp_nxt = (pp == LAST) ? '0 : pp + 1'b1;
      if (push_ok) wp_nxt = wp + 1'b1;
      if (RES_push_i && (wp == WP_FULL)) err_nxt = 1'b1;
      // A push landing on the done cycle counts towards the completeness check.
      if (done_i) begin
        state_nxt = DRAIN;
        if (wp_nxt != WP_FULL) err_nxt = 1'b1;
      end
    end
    if (drain_acc) begin
      rp_nxt = (rp == LAST) ? '0 : rp + 1'b1;
      if (rp == LAST) state_nxt = IDLE;
    end

    a_nxt = '0;
    idx   = 0;
    for (int k = 0; k < PE_NB; k++) begin
      idx = int'(g_nxt) * PE_NB + k;
      if (idx < s) a_nxt[17*k +: 17] = a_mem[idx[AW-1:0]];
    end
  end

  // Storage is deliberately outside the reset domain so a reset keeps operands.
  always_ff @(posedge clock_i) begin
    if (!reset_i && ld_acc) begin
      case (load_sel_i)
        2'd0:    a_mem[la] <= load_word_i;
        2'd1:    b_mem[lb] <= load_word_i;
        2'd2:    p_mem[lp] <= load_word_i;
        default: ;
      endcase
    end
    if (!reset_i && push_ok) r_mem[wp[AW-1:0]] <= RES_i;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state        <= IDLE;
      la           <= '0;
      lb           <= '0;
      lp           <= '0;
      bp           <= '0;
      pp           <= '0;
      rp           <= '0;
      wp           <= '0;
      g            <= '0;
      err_o        <= 1'b0;
      start_o      <= 1'b0;
      busy_o       <= 1'b0;
      load_ready_o <= 1'b1;
      res_valid_o  <= 1'b0;
      a_o          <= '0;
      b_o          <= '0;
      p_o          <= '0;
      res_word_o   <= '0;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      bp    <= bp_nxt;
      pp    <= pp_nxt;
      wp    <= wp_nxt;
      rp    <= rp_nxt;
      err_o <= err_nxt;
      if (go_acc) begin
        la <= '0;
        lb <= '0;
        lp <= '0;
      end else if (ld_acc) begin
        case (load_sel_i)
          2'd0:    la <= (la == LAST) ? '0 : la + 1'b1;
          2'd1:    lb <= (lb == LAST) ? '0 : lb + 1'b1;
          2'd2:    lp <= (lp == LAST) ? '0 : lp + 1'b1;
          default: ;
        endcase
      end
      start_o      <= go_acc;
      busy_o       <= (state_nxt != IDLE);
      load_ready_o <= (state_nxt == IDLE);
      res_valid_o  <= (state_nxt == DRAIN);
      if (state_nxt == RUN) begin
        a_o <= a_nxt;
        b_o <= b_mem[bp_nxt];
        p_o <= p_mem[pp_nxt];
      end
      if (state_nxt == DRAIN) res_word_o <= r_mem[rp_nxt];
    end
  end

endmodule

// File: tb/tb_fios_operand_server.sv
// Randomised and directed bench for fios_operand_server (s=4, PE_NB=2) against
// a behavioural model built from counts of strobes and plain array indexing.
module tb_fios_operand_server;

  localparam int S  = 4;
  localparam int PE = 2;
  localparam int NW = (S + PE - 1) / PE;

  logic clock = 1'b0;
  logic reset_i, load_valid_i, load_ready_o, go_i, busy_o, start_o;
  logic [1:0] load_sel_i;
  logic [16:0] load_word_i, b_o, p_o, RES_i, res_word_o;
  logic [PE*17-1:0] a_o;
  logic a_shift_i, b_fetch_i, p_fetch_i, RES_push_i, done_i;
  logic res_valid_o, res_ready_i, err_o;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [16:0] ma [S];
  logic [16:0] mb [S];
  logic [16:0] mp [S];
  logic [16:0] mr [S];
  int n_shift, n_b, n_p, n_push;
  logic m_err;
  logic [16:0] drained [S];
  int drained_n;

  fios_operand_server #(.s(S), .PE_NB(PE)) dut (
    .clock_i(clock), .reset_i(reset_i),
    .load_valid_i(load_valid_i), .load_sel_i(load_sel_i), .load_word_i(load_word_i),
    .load_ready_o(load_ready_o), .go_i(go_i), .busy_o(busy_o), .start_o(start_o),
    .a_o(a_o), .a_shift_i(a_shift_i), .b_o(b_o), .p_o(p_o),
    .b_fetch_i(b_fetch_i), .p_fetch_i(p_fetch_i),
    .RES_push_i(RES_push_i), .RES_i(RES_i), .done_i(done_i),
    .res_valid_o(res_valid_o), .res_word_o(res_word_o), .res_ready_i(res_ready_i),
    .err_o(err_o)
  );

  initial forever #5 clock = ~clock;

  function automatic logic [PE*17-1:0] exp_win(input int shifts);
    int gw;
    logic [PE*17-1:0] w;
    gw = (shifts > NW) ? NW : shifts;
    w = '0;
    for (int k = 0; k < PE; k++)
      if (gw * PE + k < S) w[17*k +: 17] = ma[gw * PE + k];
    return w;
  endfunction

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic load_op(input logic [1:0] sel, input logic [16:0] w);
    load_valid_i = 1'b1; load_sel_i = sel; load_word_i = w;
    cycle();
    load_valid_i = 1'b0;
    if (sel == 2'd0) ma[n_shift] = w;
  endtask

  task automatic load_all(input logic [16:0] a [S], input logic [16:0] b [S], input logic [16:0] p [S]);
    for (int i = 0; i < S; i++) begin load_valid_i = 1; load_sel_i = 0; load_word_i = a[i]; cycle(); ma[i] = a[i]; end
    for (int i = 0; i < S; i++) begin load_valid_i = 1; load_sel_i = 1; load_word_i = b[i]; cycle(); mb[i] = b[i]; end
    for (int i = 0; i < S; i++) begin load_valid_i = 1; load_sel_i = 2; load_word_i = p[i]; cycle(); mp[i] = p[i]; end
    load_valid_i = 0;
  endtask

  task automatic do_go();
    go_i = 1'b1;
    cycle();
    go_i = 1'b0;
    n_shift = 0; n_b = 0; n_p = 0; n_push = 0; m_err = 1'b0;
  endtask

  task automatic push(input logic [16:0] w);
    RES_push_i = 1'b1; RES_i = w;
    cycle();
    RES_push_i = 1'b0;
    if (n_push < S) mr[n_push] = w; else m_err = 1'b1;
    n_push++;
  endtask

  task automatic do_done();
    done_i = 1'b1;
    cycle();
    done_i = 1'b0;
    if (n_push != S) m_err = 1'b1;
  endtask

  task automatic drain(input bit rnd);
    drained_n = 0;
    for (int c = 0; c < 60 && drained_n < S; c++) begin
      res_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (res_valid_o && res_ready_i) begin
        drained[drained_n] = res_word_o;
        drained_n++;
      end
      cycle();
    end
    res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    cycle(); cycle();
    reset_i = 1'b0;
    checks++;
    if ({load_ready_o, busy_o, start_o, res_valid_o, err_o} !== 5'b10000) begin
      errors++; $display("[TB] FAIL reset_flags got=%b exp=10000", {load_ready_o, busy_o, start_o, res_valid_o, err_o});
    end
    checks++;
    if ({a_o, b_o, p_o, res_word_o} !== '0) begin
      errors++; $display("[TB] FAIL reset_data got a=%h b=%h p=%h r=%h exp all 0", a_o, b_o, p_o, res_word_o);
    end
  endtask

  task automatic test_load_launch();
    logic [16:0] a [S] = '{17'd1, 17'd2, 17'd3, 17'd4};
    logic [16:0] b [S] = '{17'd5, 17'd6, 17'd7, 17'd8};
    logic [16:0] p [S] = '{17'd9, 17'd10, 17'd11, 17'd12};
    load_all(a, b, p);
    do_go();
    checks++;
    if ({start_o, busy_o, load_ready_o} !== 3'b110) begin
      errors++; $display("[TB] FAIL launch_flags got=%b exp=110", {start_o, busy_o, load_ready_o});
    end
    checks++;
    if (a_o !== {17'd2, 17'd1} || b_o !== 17'd5 || p_o !== 17'd9) begin
      errors++; $display("[TB] FAIL launch_data got a=%h b=%0d p=%0d exp a=%h b=5 p=9", a_o, b_o, p_o, {17'd2, 17'd1});
    end
    cycle();
    checks++;
    if (start_o !== 1'b0) begin errors++; $display("[TB] FAIL start_pulse got=%b exp=0", start_o); end
  endtask

  task automatic test_window();
    logic [PE*17-1:0] exp_seq [3];
    exp_seq[0] = {17'd4, 17'd3};
    exp_seq[1] = '0;
    exp_seq[2] = '0;
    for (int i = 0; i < 3; i++) begin
      a_shift_i = 1'b1; cycle(); a_shift_i = 1'b0; n_shift++;
      checks++;
      if (a_o !== exp_seq[i]) begin
        errors++; $display("[TB] FAIL a_window_%0d got=%h exp=%h", i, a_o, exp_seq[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int eb [5] = '{6, 7, 8, 5, 6};
    int ep [5] = '{10, 11, 12, 9, 10};
    for (int i = 0; i < 5; i++) begin
      b_fetch_i = 1'b1; p_fetch_i = 1'b1; cycle();
      checks++;
      if (b_o !== 17'(eb[i]) || p_o !== 17'(ep[i])) begin
        errors++; $display("[TB] FAIL bp_wrap_%0d got b=%0d p=%0d exp b=%0d p=%0d", i, b_o, p_o, eb[i], ep[i]);
      end
    end
    b_fetch_i = 1'b0; p_fetch_i = 1'b0; n_b += 5; n_p += 5;
    cycle();
    checks++;
    if (b_o !== 17'd6 || p_o !== 17'd10) begin
      errors++; $display("[TB] FAIL bp_hold got b=%0d p=%0d exp b=6 p=10", b_o, p_o);
    end
  endtask

  task automatic test_drain();
    logic [16:0] w [S] = '{17'h1, 17'h2, 17'h3, 17'h1FFFF};
    int idx = 0;
    for (int i = 0; i < S; i++) push(w[i]);
    do_done();
    for (int c = 0; c < 30 && idx < S; c++) begin
      res_ready_i = (c % 3) != 0;
      checks++;
      if (res_valid_o !== 1'b1 || res_word_o !== w[idx]) begin
        errors++; $display("[TB] FAIL drain_word_%0d got v=%b w=%h exp v=1 w=%h", idx, res_valid_o, res_word_o, w[idx]);
      end
      if (res_ready_i) idx++;
      cycle();
    end
    res_ready_i = 1'b0;
    checks++;
    if ({load_ready_o, busy_o, res_valid_o, err_o} !== 4'b1000 || idx != S) begin
      errors++; $display("[TB] FAIL drain_end got flags=%b words=%0d exp flags=1000 words=%0d", {load_ready_o, busy_o, res_valid_o, err_o}, idx, S);
    end
  endtask

  task automatic test_push_overflow();
    do_go();
    for (int i = 0; i < S; i++) push(17'($urandom));
    push(17'h0AAAA);
    checks++;
    if (err_o !== m_err) begin errors++; $display("[TB] FAIL overflow_err got=%b exp=%b", err_o, m_err); end
    do_done();
    drain(1'b0);
    checks++;
    if (drained_n != S || drained[0] !== mr[0] || drained[1] !== mr[1] || drained[2] !== mr[2] || drained[3] !== mr[3]) begin
      errors++; $display("[TB] FAIL overflow_data got n=%0d last=%h exp n=%0d last=%h", drained_n, drained[3], S, mr[3]);
    end
    do_go();
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL overflow_go_clear got=%b exp=0", err_o); end
  endtask

  task automatic test_done_early();
    for (int i = 0; i < S - 1; i++) push(17'($urandom));
    do_done();
    checks++;
    if (err_o !== 1'b1 || res_valid_o !== 1'b1) begin
      errors++; $display("[TB] FAIL early_done got err=%b v=%b exp err=1 v=1", err_o, res_valid_o);
    end
    drain(1'b1);
    checks++;
    if (drained_n != S || drained[2] !== mr[2] || drained[3] !== mr[3]) begin
      errors++; $display("[TB] FAIL early_data got n=%0d w2=%h w3=%h exp n=%0d w2=%h w3=%h", drained_n, drained[2], drained[3], S, mr[2], mr[3]);
    end
    do_go();
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL early_go_clear got=%b exp=0", err_o); end
  endtask

  task automatic test_reset_mid_run();
    b_fetch_i = 1'b1; cycle(); cycle(); b_fetch_i = 1'b0;
    checks++;
    if (b_o !== mb[2]) begin errors++; $display("[TB] FAIL mid_fetch got=%0d exp=%0d", b_o, mb[2]); end
    reset_i = 1'b1; cycle(); reset_i = 1'b0;
    checks++;
    if ({load_ready_o, busy_o, err_o} !== 3'b100 || b_o !== 17'd0) begin
      errors++; $display("[TB] FAIL mid_reset got flags=%b b=%0d exp flags=100 b=0", {load_ready_o, busy_o, err_o}, b_o);
    end
    do_go();
    checks++;
    if (b_o !== 17'd5 || p_o !== 17'd9 || a_o !== exp_win(0)) begin
      errors++; $display("[TB] FAIL mid_relaunch got b=%0d p=%0d a=%h exp b=5 p=9 a=%h", b_o, p_o, a_o, exp_win(0));
    end
    reset_i = 1'b1; cycle(); reset_i = 1'b0;
  endtask

  task automatic test_random();
    logic [16:0] a [S];
    logic [16:0] b [S];
    logic [16:0] p [S];
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < S; i++) begin a[i] = 17'($urandom); b[i] = 17'($urandom); p[i] = 17'($urandom); end
      load_all(a, b, p);
      do_go();
      checks++;
      if (a_o !== exp_win(0) || b_o !== mb[0] || p_o !== mp[0]) begin
        errors++; $display("[TB] FAIL rnd_launch_%0d got a=%h b=%h p=%h", it, a_o, b_o, p_o);
      end
      for (int c = 0; c < 20; c++) begin
        a_shift_i = 1'($urandom_range(0, 1));
        b_fetch_i = 1'($urandom_range(0, 1));
        p_fetch_i = 1'($urandom_range(0, 1));
        RES_push_i = (n_push < S) ? 1'($urandom_range(0, 3) == 0) : (it == 3 && c == 19);
        RES_i = 17'($urandom);
        cycle();
        if (a_shift_i) n_shift++;
        if (b_fetch_i) n_b++;
        if (p_fetch_i) n_p++;
        if (RES_push_i) begin
          if (n_push < S) mr[n_push] = RES_i; else m_err = 1'b1;
          n_push++;
        end
        checks++;
        if (a_o !== exp_win(n_shift) || b_o !== mb[n_b % S] || p_o !== mp[n_p % S] || err_o !== m_err) begin
          errors++; $display("[TB] FAIL rnd_run_%0d_%0d got a=%h b=%h p=%h e=%b exp a=%h b=%h p=%h e=%b",
                             it, c, a_o, b_o, p_o, err_o, exp_win(n_shift), mb[n_b % S], mp[n_p % S], m_err);
        end
      end
      a_shift_i = 0; b_fetch_i = 0; p_fetch_i = 0; RES_push_i = 0;
      while (n_push < S) push(17'($urandom));
      if (n_push > S) n_push = S;
      do_done();
      checks++;
      if (err_o !== m_err) begin errors++; $display("[TB] FAIL rnd_err_%0d got=%b exp=%b", it, err_o, m_err); end
      drain(1'b1);
      checks++;
      if (drained_n != S || drained[0] !== mr[0] || drained[1] !== mr[1] || drained[2] !== mr[2] || drained[3] !== mr[3]) begin
        errors++; $display("[TB] FAIL rnd_drain_%0d got n=%0d w0=%h w3=%h exp n=%0d w0=%h w3=%h", it, drained_n, drained[0], drained[3], S, mr[0], mr[3]);
      end
    end
  endtask

  initial begin
    reset_i = 1'b1; load_valid_i = 0; load_sel_i = 0; load_word_i = 0; go_i = 0;
    a_shift_i = 0; b_fetch_i = 0; p_fetch_i = 0; RES_push_i = 0; RES_i = 0;
    done_i = 0; res_ready_i = 0;
    n_shift = 0; n_b = 0; n_p = 0; n_push = 0; m_err = 0; drained_n = 0;
    test_reset();
    test_load_launch();
    test_window();
    test_wrap();
    test_drain();
    test_push_overflow();
    test_done_early();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
